// File: rtl/dmem_mover_pkg.sv
// rtl/dmem_mover_pkg.sv - shared modes, states and sizes for the data-memory mover
package dmem_mover_pkg;

  localparam int AW_DEF  = 6;
  localparam int DW_DEF  = 32;
  localparam int MAX_LEN = 64;

  localparam logic [1:0] MODE_COPY  = 2'b00;
  localparam logic [1:0] MODE_FILL  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_CHK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dmem_agen.sv
// rtl/dmem_agen.sv - wrapping source/destination pointer pair with word counter and terminal flag
module dmem_agen #(
  parameter int AW = 6,
  parameter int LW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src_init,
  input  logic [AW-1:0] dst_init,
  input  logic [LW-1:0] len_init,
  output logic [AW-1:0] dst_ptr,
  output logic [AW-1:0] src_next,
  output logic [AW-1:0] dst_next,
  output logic          last
);

  logic [AW-1:0] src_ptr;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      len_r   <= '0;
    end else if (load) begin
      src_ptr <= src_init;
      dst_ptr <= dst_init;
      cnt     <= '0;
      len_r   <= len_init;
    end else if (step) begin
      src_ptr <= src_next;
      dst_ptr <= dst_next;
      cnt     <= cnt + LW'(1);
    end
  end

  // Pointers are exactly AW bits wide, so the increment wraps modulo the memory depth.
  assign src_next = src_ptr + AW'(1);
  assign dst_next = dst_ptr + AW'(1);
  assign last     = (cnt + LW'(1)) == len_r;

endmodule

// File: rtl/dmem_mover.sv
// rtl/dmem_mover.sv - COPY/FILL/CHECK block engine driving the single-port data memory
module dmem_mover
  import dmem_mover_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] err_cnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  state_t        state;
  logic [DW-1:0] pattern_r;
  logic          fill_we;
  logic [LW-1:0] len_c;
  logic          load;
  logic          step;
  logic          last;
  logic          finish;
  logic [AW-1:0] dst_ptr;
  logic [AW-1:0] src_next;
  logic [AW-1:0] dst_next;

  assign len_c  = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign load   = (state == ST_IDLE) && start;
  assign step   = (state == ST_WR) || (state == ST_FILL) || (state == ST_CHK);
  assign finish = step && last;

  dmem_agen #(.AW(AW), .LW(LW)) u_agen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .src_init (src),
    .dst_init (dst),
    .len_init (len_c),
    .dst_ptr  (dst_ptr),
    .src_next (src_next),
    .dst_next (dst_next),
    .last     (last)
  );

  // Memory-side outputs are registered, so each transition loads what the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_d     <= '0;
      pattern_r <= '0;
      fill_we   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_CHK && mem_q != pattern_r && err_cnt != LW'(MAX_LEN))
        err_cnt <= err_cnt + LW'(1);
      if (finish) begin
        state  <= ST_DONE;
        done   <= 1'b1;
        busy   <= 1'b0;
        mem_we <= 1'b0;
        mem_a  <= '0;
        mem_d  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              pattern_r <= pattern;
              err_cnt   <= '0;
              fill_we   <= (mode != MODE_RSVD);
              if (len_c == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                busy <= 1'b1;
                case (mode)
                  MODE_COPY: begin
                    state <= ST_RD;
                    mem_a <= src;
                  end
                  MODE_CHECK: begin
                    state <= ST_CHK;
                    mem_a <= src;
                  end
                  default: begin
                    state  <= ST_FILL;
                    mem_a  <= dst;
                    mem_d  <= pattern;
                    mem_we <= (mode != MODE_RSVD);
                  end
                endcase
              end
            end
          end
          ST_RD: begin
            // mem_d doubles as the hold register for the word just read.
            state  <= ST_WR;
            mem_a  <= dst_ptr;
            mem_d  <= mem_q;
            mem_we <= 1'b1;
          end
          ST_WR: begin
            state  <= ST_RD;
            mem_a  <= src_next;
            mem_d  <= '0;
            mem_we <= 1'b0;
          end
          ST_FILL: begin
            mem_a  <= dst_next;
            mem_d  <= pattern_r;
            mem_we <= fill_we;
          end
          ST_CHK: begin
            mem_a <= src_next;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mover.sv
// tb/tb_dmem_mover.sv - scoreboard bench for dmem_mover with a behavioural 64x32 memory
module tb_dmem_mover;
  import dmem_mover_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [5:0]  src;
  logic [5:0]  dst;
  logic [6:0]  len;
  logic [31:0] pattern;
  logic        busy;
  logic        done;
  logic [6:0]  err_cnt;
  logic        mem_we;
  logic [5:0]  mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  logic [31:0] mem [0:63];
  logic        init_en = 1'b0;
  logic [31:0] init_val = '0;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_a = '0;
  logic [31:0] poke_d = '0;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; int err; int bsy; } dn_t;
  wr_t exp_wr[$];
  int  exp_rd[$];
  dn_t exp_done[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;

  dmem_mover dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .pattern (pattern),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_q   (mem_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_q = mem[mem_a];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_we) begin
      mem[mem_a] <= mem_d;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes, reads, or signals done.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_we) begin
        chk("wr_expected", 64'(exp_wr.size() > 0), 64'(1));
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(mem_a), 64'(w.addr));
          chk("wr_data", 64'(mem_d), 64'(w.data));
        end
      end
      if (busy && !mem_we && exp_rd.size() > 0) begin
        int a;
        a = exp_rd.pop_front();
        chk("rd_addr", 64'(mem_a), 64'(a));
      end
      if (done) begin
        chk("done_expected", 64'(exp_done.size() > 0), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(0));
        if (exp_done.size() > 0) begin
          dn_t d;
          d = exp_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("err_cnt", 64'(err_cnt), 64'(d.err));
          chk("busy_cycles", 64'(busy_cnt), 64'(d.bsy));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic init_mem(input logic [31:0] v);
    @(negedge clk); init_en = 1'b1; init_val = v;
    @(negedge clk); init_en = 1'b0;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    @(negedge clk); poke_en = 1'b1; poke_a = 6'(a); poke_d = v;
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] m, input int s, input int d, input int l,
                    input logic [31:0] p, input int lat, input int err, input int bsy);
    @(negedge clk);
    mode = m; src = 6'(s); dst = 6'(d); len = 7'(l); pattern = p; start = 1'b1;
    exp_done.push_back('{cyc + lat, err, bsy});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_done.size() + exp_wr.size() + exp_rd.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_complete"}, 64'(n < 200), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int nbad;
    rst = 1'b1; start = 1'b0; mode = MODE_COPY; src = '0; dst = '0; len = '0; pattern = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err_cnt), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_a", 64'(mem_a), 64'(0));
    chk("rst_d", 64'(mem_d), 64'(0));
    rst = 1'b0;

    // FILL dst=4 len=3
    init_mem(32'hFFFF_FFFF);
    for (int i = 4; i < 7; i++) exp_wr.push_back('{i, 32'hA5A5_A5A5});
    go(MODE_FILL, 0, 4, 3, 32'hA5A5_A5A5, 4, 0, 3);
    wait_quiet("fill");
    chk("fill_m3", 64'(mem[3]), 64'hFFFF_FFFF);
    chk("fill_m4", 64'(mem[4]), 64'hA5A5_A5A5);
    chk("fill_m6", 64'(mem[6]), 64'hA5A5_A5A5);
    chk("fill_m7", 64'(mem[7]), 64'hFFFF_FFFF);

    // COPY src=0 dst=32 len=2
    poke(0, 32'h11);
    poke(1, 32'h22);
    exp_rd.push_back(0); exp_rd.push_back(1);
    exp_wr.push_back('{32, 32'h11}); exp_wr.push_back('{33, 32'h22});
    go(MODE_COPY, 0, 32, 2, 32'h0, 5, 0, 4);
    wait_quiet("copy");
    chk("copy_m32", 64'(mem[32]), 64'h11);
    chk("copy_m33", 64'(mem[33]), 64'h22);

    // CHECK src=62 len=4 wraps through 63,0,1
    init_mem(32'hFFFF_FFFF);
    poke(63, 32'h0);
    poke(1, 32'h0);
    exp_rd.push_back(62); exp_rd.push_back(63); exp_rd.push_back(0); exp_rd.push_back(1);
    go(MODE_CHECK, 62, 0, 4, 32'hFFFF_FFFF, 5, 2, 4);
    wait_quiet("check");
    repeat (3) @(negedge clk);
    chk("err_hold", 64'(err_cnt), 64'(2));

    // len=0 in COPY and FILL: done next cycle, no writes, err_cnt cleared
    go(MODE_COPY, 0, 40, 0, 32'h0, 1, 0, 0);
    wait_quiet("len0_copy");
    go(MODE_FILL, 0, 40, 0, 32'h1234, 1, 0, 0);
    wait_quiet("len0_fill");
    chk("len0_m40", 64'(mem[40]), 64'hFFFF_FFFF);

    // len=100 clamps to 64 and wraps from dst=5
    for (int i = 0; i < 64; i++) exp_wr.push_back('{(5 + i) % 64, 32'h5A5A_0000});
    go(MODE_FILL, 0, 5, 100, 32'h5A5A_0000, 65, 0, 64);
    wait_quiet("clamp");
    nbad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 32'h5A5A_0000) nbad++;
    chk("clamp_all_words", 64'(nbad), 64'(0));

    // start re-pulsed while busy is ignored
    init_mem(32'hFFFF_FFFF);
    for (int i = 20; i < 23; i++) exp_wr.push_back('{i, 32'h1234_5678});
    go(MODE_FILL, 0, 20, 3, 32'h1234_5678, 4, 0, 3);
    mode = MODE_COPY; dst = 6'd50; len = 7'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet("repulse");
    chk("repulse_m50", 64'(mem[50]), 64'hFFFF_FFFF);

    // start together with rst stays idle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mode = MODE_FILL; dst = 6'd0; len = 7'd5; pattern = 32'h0;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 64'(busy), 64'(0));
    chk("rst_start_m0", 64'(mem[0]), 64'hFFFF_FFFF);

    // rst on the third cycle of FILL dst=10 len=8
    exp_wr.push_back('{10, 32'hC3C3_C3C3}); exp_wr.push_back('{11, 32'hC3C3_C3C3});
    @(negedge clk);
    mode = MODE_FILL; dst = 6'd10; len = 7'd8; pattern = 32'hC3C3_C3C3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_we", 64'(mem_we), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_writes_seen", 64'(exp_wr.size()), 64'(0));
    chk("abort_m11", 64'(mem[11]), 64'hC3C3_C3C3);
    chk("abort_m12", 64'(mem[12]), 64'hFFFF_FFFF);
    chk("abort_m17", 64'(mem[17]), 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
